// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ valid/ready streams.
// A grant is locked for a burst that ends on an accepted last beat or after MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  input  logic [NREQ-1:0]       req_last_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic [NREQ-1:0]       grant_o,
  output logic                  busy_o,
  output logic [WIDTH-1:0]      fifo_wdata_o,
  output logic                  fifo_we_o,
  input  logic                  fifo_full_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   prio_ptr_q, prio_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [WIDTH-1:0] data_arr [NREQ];
  logic             owner_valid;
  logic             owner_last;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [CW-1:0]    beat_cnt_inc;

  assign busy_o = (state_q == BURST);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign data_arr[gi]    = req_data_i[gi*WIDTH +: WIDTH];
      assign grant_o[gi]     = busy_o && (owner_q == IW'(gi));
      assign req_ready_o[gi] = grant_o[gi] & ~fifo_full_i;
    end
  endgenerate

  assign owner_valid  = req_valid_i[owner_q];
  assign owner_last   = req_last_i[owner_q];
  assign fifo_we_o    = busy_o & owner_valid & ~fifo_full_i;
  assign fifo_wdata_o = busy_o ? data_arr[owner_q] : '0;
  assign beat_cnt_inc = beat_cnt_q + 1'b1;

  // Scan from farthest to nearest so the requester closest after prio_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      int sum;
      logic [IW-1:0] idx;
      sum = int'(prio_ptr_q) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IW'(sum);
      if (req_valid_i[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_ptr_d = prio_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (win_found) begin
        owner_d    = win_idx;
        beat_cnt_d = '0;
        state_d    = BURST;
      end
    end else begin
      // Owner stalls and FIFO-full cycles leave the grant and count untouched.
      if (fifo_we_o) begin
        beat_cnt_d = beat_cnt_inc;
        if (owner_last || (beat_cnt_inc == CW'(MAX_BURST))) begin
          state_d    = IDLE;
          prio_ptr_d = owner_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      prio_ptr_q <= IW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_ptr_q <= prio_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester queues drive the streams, every
// FIFO write is popped against the expected (grant, data) order.
module tb_fifo_wr_arbiter;
  localparam int WIDTH     = 32;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 8;

  typedef logic [WIDTH:0] beat_t;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [NREQ-1:0]       req_valid_i = '0;
  logic [NREQ*WIDTH-1:0] req_data_i = '0;
  logic [NREQ-1:0]       req_last_i = '0;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ-1:0]       grant_o;
  logic                  busy_o;
  logic [WIDTH-1:0]      fifo_wdata_o;
  logic                  fifo_we_o;
  logic                  fifo_full_i = 1'b0;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_last_i   (req_last_i),
    .req_ready_o  (req_ready_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_we_o    (fifo_we_o),
    .fifo_full_i  (fifo_full_i)
  );

  always #5 clk_i = ~clk_i;

  beat_t            rq [NREQ][$];
  logic [WIDTH-1:0] exp_d [$];
  logic [NREQ-1:0]  exp_g [$];
  int               wcyc [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_v = 1'b1;
  logic full_v = 1'b0;
  logic sb_en = 1'b1;

  logic [NREQ-1:0]  grant_s, ready_s;
  logic             busy_s, we_s;
  logic [WIDTH-1:0] wdata_s;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] acc;
    beat_t b;
    @(negedge clk_i);
    rst_i = rst_v;
    fifo_full_i = full_v;
    for (int k = 0; k < NREQ; k++) begin
      if (rq[k].size() > 0) begin
        b = rq[k][0];
        req_valid_i[k] = 1'b1;
        req_data_i[k*WIDTH +: WIDTH] = b[WIDTH-1:0];
        req_last_i[k] = b[WIDTH];
      end else begin
        req_valid_i[k] = 1'b0;
        req_data_i[k*WIDTH +: WIDTH] = '0;
        req_last_i[k] = 1'b0;
      end
    end
    #1;
    grant_s = grant_o; ready_s = req_ready_o; busy_s = busy_o;
    we_s = fifo_we_o; wdata_s = fifo_wdata_o;
    chk("we_while_full", 64'(fifo_we_o & fifo_full_i), 64'd0);
    chk("ready_non_owner", 64'(req_ready_o & ~grant_o), 64'd0);
    if (fifo_we_o) begin
      wcyc.push_back(cyc);
      if (sb_en) begin
        if (exp_d.size() == 0) chk("unexpected_write", 64'(fifo_wdata_o), 64'hdead_0000_0000);
        else begin
          chk("wdata", 64'(fifo_wdata_o), 64'(exp_d.pop_front()));
          chk("wgrant", 64'(grant_o), 64'(exp_g.pop_front()));
        end
      end
    end
    acc = req_valid_i & req_ready_o;
    @(posedge clk_i);
    for (int k = 0; k < NREQ; k++)
      if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    cyc++;
  endtask

  task automatic beat(input int k, input logic [WIDTH-1:0] d, input logic last, input logic add_exp);
    rq[k].push_back({last, d});
    if (add_exp) begin
      exp_d.push_back(d);
      exp_g.push_back(NREQ'(1) << k);
    end
  endtask

  task automatic expect_w(input int k, input logic [WIDTH-1:0] d);
    exp_d.push_back(d);
    exp_g.push_back(NREQ'(1) << k);
  endtask

  task automatic run_until_done(input int budget);
    int n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      step();
      n++;
      pending = (exp_d.size() != 0);
      for (int k = 0; k < NREQ; k++) if (rq[k].size() != 0) pending = 1'b1;
    end
    if (pending) chk("drain_timeout", 64'(n), 64'(budget + 1));
  endtask

  initial begin
    int c0;
    // Reset state
    step();
    step();
    chk("rst_grant", 64'(grant_s), 64'd0);
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_ready", 64'(ready_s), 64'd0);
    chk("rst_we", 64'(we_s), 64'd0);
    chk("rst_wdata", 64'(wdata_s), 64'd0);
    rst_v = 1'b0;
    step();

    // Single packet from requester 0
    wcyc.delete();
    beat(0, 32'hA0, 1'b0, 1'b1);
    beat(0, 32'hA1, 1'b0, 1'b1);
    beat(0, 32'hA2, 1'b1, 1'b1);
    c0 = cyc;
    step();
    chk("sp_idle_grant", 64'(grant_s), 64'd0);
    run_until_done(20);
    chk("sp_first_cycle", 64'(wcyc[0]), 64'(c0 + 1));
    chk("sp_last_cycle", 64'(wcyc[2]), 64'(c0 + 3));
    step();
    chk("sp_idle_after", 64'(busy_s), 64'd0);

    // Round robin: last owner 0, so order continues 1,2,3,0,...
    wcyc.delete();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NREQ; k++) beat(k, WIDTH'(32'h10 * k + p), 1'b1, 1'b0);
    for (int p = 0; p < 2; p++)
      for (int j = 1; j <= NREQ; j++) expect_w(j % NREQ, WIDTH'(32'h10 * (j % NREQ) + p));
    run_until_done(40);
    for (int i = 0; i < 7; i++) chk("rr_gap", 64'(wcyc[i+1] - wcyc[i]), 64'd2);

    // MAX_BURST cut with a competing requester
    wcyc.delete();
    for (int i = 0; i < 16; i++) beat(2, WIDTH'(32'h200 + i), 1'b0, 1'b0);
    beat(0, 32'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) expect_w(2, WIDTH'(32'h200 + i));
    expect_w(0, 32'hAA);
    for (int i = 8; i < 16; i++) expect_w(2, WIDTH'(32'h200 + i));
    run_until_done(60);
    chk("cut_gap_a", 64'(wcyc[8] - wcyc[7]), 64'd2);
    chk("cut_gap_b", 64'(wcyc[9] - wcyc[8]), 64'd2);

    // MAX_BURST cut with requester 2 alone
    wcyc.delete();
    for (int i = 0; i < 16; i++) beat(2, WIDTH'(32'h300 + i), 1'b0, 1'b1);
    run_until_done(60);
    chk("cut_alone_gap", 64'(wcyc[8] - wcyc[7]), 64'd2);
    chk("cut_alone_run", 64'(wcyc[7] - wcyc[0]), 64'd7);

    // last coinciding with the MAX_BURST-th beat ends one burst only
    wcyc.delete();
    for (int i = 0; i < 8; i++) beat(1, WIDTH'(32'h400 + i), (i == 7), 1'b1);
    beat(1, 32'h408, 1'b1, 1'b1);
    run_until_done(40);
    chk("coincide_gap", 64'(wcyc[8] - wcyc[7]), 64'd2);

    // Backpressure during requester 1's burst
    for (int i = 0; i < 5; i++) beat(1, WIDTH'(32'h500 + i), (i == 4), 1'b1);
    step();
    step();
    step();
    full_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_we", 64'(we_s), 64'd0);
      chk("bp_ready1", 64'(ready_s[1]), 64'd0);
      chk("bp_grant", 64'(grant_s), 64'h2);
    end
    full_v = 1'b0;
    step();
    chk("bp_resume", 64'(we_s), 64'd1);
    run_until_done(20);

    // Owner stall: requester 3 keeps the grant while requester 0 waits
    beat(3, 32'h600, 1'b0, 1'b1);
    beat(3, 32'h601, 1'b0, 1'b1);
    beat(0, 32'hBB, 1'b1, 1'b0);
    expect_w(3, 32'h602);
    expect_w(3, 32'h603);
    expect_w(0, 32'hBB);
    step();
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_grant", 64'(grant_s), 64'h8);
      chk("stall_we", 64'(we_s), 64'd0);
    end
    rq[3].push_back({1'b0, 32'h602});
    rq[3].push_back({1'b1, 32'h603});
    run_until_done(20);

    // Reset mid-burst, then requester 0 wins despite requester 2 being valid
    for (int i = 0; i < 5; i++) beat(2, WIDTH'(32'h700 + i), (i == 4), 1'b0);
    expect_w(2, 32'h700);
    expect_w(2, 32'h701);
    step();
    step();
    step();
    chk("mid_sb_drained", 64'(exp_d.size()), 64'd0);
    sb_en = 1'b0;
    rst_v = 1'b1;
    step();
    step();
    chk("mid_rst_grant", 64'(grant_s), 64'd0);
    chk("mid_rst_we", 64'(we_s), 64'd0);
    chk("mid_rst_busy", 64'(busy_s), 64'd0);
    chk("mid_rst_wdata", 64'(wdata_s), 64'd0);
    rst_v = 1'b0;
    rq[2].delete();
    exp_d.delete();
    exp_g.delete();
    sb_en = 1'b1;
    beat(2, 32'h7A0, 1'b1, 1'b0);
    beat(0, 32'h7B0, 1'b1, 1'b0);
    expect_w(0, 32'h7B0);
    expect_w(2, 32'h7A0);
    run_until_done(20);

    step();
    chk("final_sb_empty", 64'(exp_d.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
